// File: rtl/div_share_arb_if.sv
// div_share_arb_if: groups the requester-side and divider-side handshake
// signals of the shared-divider arbiter into one bundle.
//   slave  modport : the arbiter's view (requests and divider results in,
//                    acks/dones/result and divider operands out)
//   master modport : the surrounding environment's view (opposite directions)
// Ports carried: req0/1, dvd0/1, dvs0/1, ack0/1, done0/1, res_q, res_err,
//                div_start, div_dvd, div_dvs, div_busy, div_valid, div_ovf,
//                div_dvz, div_q.
interface div_share_arb_if #(
    parameter int W = 10
);
    logic         req0;
    logic         req1;
    logic [W-1:0] dvd0;
    logic [W-1:0] dvd1;
    logic [W-1:0] dvs0;
    logic [W-1:0] dvs1;
    logic         ack0;
    logic         ack1;
    logic         done0;
    logic         done1;
    logic [W-1:0] res_q;
    logic [1:0]   res_err;
    logic         div_start;
    logic [W-1:0] div_dvd;
    logic [W-1:0] div_dvs;
    logic         div_busy;
    logic         div_valid;
    logic         div_ovf;
    logic         div_dvz;
    logic [W-1:0] div_q;

    modport slave (
        input  req0, req1, dvd0, dvd1, dvs0, dvs1,
        input  div_busy, div_valid, div_ovf, div_dvz, div_q,
        output ack0, ack1, done0, done1, res_q, res_err,
        output div_start, div_dvd, div_dvs
    );

    modport master (
        output req0, req1, dvd0, dvd1, dvs0, dvs1,
        output div_busy, div_valid, div_ovf, div_dvz, div_q,
        input  ack0, ack1, done0, done1, res_q, res_err,
        input  div_start, div_dvd, div_dvs
    );
endinterface

// File: rtl/div_share_arb.sv
// div_share_arb: round-robin arbiter sharing one sequential divider between
// two requesters. The winner's operands are captured on the grant edge and
// held on div_dvd/div_dvs, a one-cycle div_start is issued, and the divider's
// result (or divide-by-zero / overflow status) is returned to the winner as a
// one-cycle done pulse. A zero divisor is answered directly without starting
// the divider.
// Ports:
//   clk  - clock, posedge
//   rst  - asynchronous active-low reset
//   bus  - div_share_arb_if.slave (requester and divider handshakes)
// Parameters: W (operand width), TMO (watchdog limit, 2..255).
// Optional feature: define DIV_ARB_TIMEOUT_EN to build an 8-bit WAIT
// watchdog that ends a stalled job with status 11 after TMO cycles.
// All outputs are registered.
module div_share_arb #(
    parameter int W   = 10,
    parameter int TMO = 64
) (
    input logic               clk,
    input logic               rst,
    div_share_arb_if.slave    bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DVZ = 2'b01;
    localparam logic [1:0] ERR_OVF = 2'b10;

    logic [1:0]   state_q,    state_d;
    logic         last_gnt_q, last_gnt_d;
    logic         tag_q,      tag_d;
    logic [W-1:0] dvd_q,      dvd_d;
    logic [W-1:0] dvs_q,      dvs_d;
    logic [W-1:0] rlat_q,     rlat_d;    // latched quotient of the finished job
    logic [1:0]   elat_q,     elat_d;    // latched status of the finished job
    logic         ack0_q,     ack0_d;
    logic         ack1_q,     ack1_d;
    logic         done0_q,    done0_d;
    logic         done1_q,    done1_d;
    logic         start_q,    start_d;
    logic [W-1:0] res_val_q,  res_val_d;
    logic [1:0]   res_err_q,  res_err_d;
    logic         win_s;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam logic [1:0] ERR_TMO = 2'b11;
    // Compared against the count of WAIT cycles already elapsed, so the exit
    // edge closes the TMO-th WAIT cycle.
    localparam logic [7:0] TMO_LIM = 8'(TMO - 1);
    logic [7:0] wd_q, wd_d;
`endif

    // Round-robin pick: on a tie the requester that did not win last time.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            win_s = ~last_gnt_q;
        end else begin
            win_s = bus.req1;
        end
    end

    // Next-state, operand capture and result latching.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        tag_d      = tag_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rlat_d     = rlat_q;
        elat_d     = elat_q;
`ifdef DIV_ARB_TIMEOUT_EN
        wd_d       = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    tag_d      = win_s;
                    last_gnt_d = win_s;
                    dvd_d      = win_s ? bus.dvd1 : bus.dvd0;
                    dvs_d      = win_s ? bus.dvs1 : bus.dvs0;
                    if (dvs_d == '0) begin
                        // Short-circuit: divider is never started.
                        state_d = S_RESP;
                        rlat_d  = '0;
                        elat_d  = ERR_DVZ;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
                wd_d    = 8'd0;
`endif
            end
            S_WAIT: begin
                if (bus.div_dvz) begin
                    state_d = S_RESP;
                    rlat_d  = '0;
                    elat_d  = ERR_DVZ;
                end else if (bus.div_ovf) begin
                    state_d = S_RESP;
                    rlat_d  = '0;
                    elat_d  = ERR_OVF;
                end else if (bus.div_valid) begin
                    state_d = S_RESP;
                    rlat_d  = bus.div_q;
                    elat_d  = ERR_OK;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                else if (wd_q == TMO_LIM) begin
                    state_d = S_RESP;
                    rlat_d  = '0;
                    elat_d  = ERR_TMO;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`else
                else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs are computed from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        start_d   = (state_d == S_ISSUE);
        ack0_d    = (state_d == S_ISSUE) && !tag_d;
        ack1_d    = (state_d == S_ISSUE) &&  tag_d;
        done0_d   = (state_d == S_RESP)  && !tag_d;
        done1_d   = (state_d == S_RESP)  &&  tag_d;
        res_val_d = (state_d == S_RESP) ? rlat_d : '0;
        res_err_d = (state_d == S_RESP) ? elat_d : 2'b00;
    end

    // State, operand, result and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            tag_q      <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rlat_q     <= '0;
            elat_q     <= 2'b00;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            start_q    <= 1'b0;
            res_val_q  <= '0;
            res_err_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            tag_q      <= tag_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rlat_q     <= rlat_d;
            elat_q     <= elat_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            start_q    <= start_d;
            res_val_q  <= res_val_d;
            res_err_q  <= res_err_d;
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    // WAIT-cycle watchdog counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.res_q     = res_val_q;
    assign bus.res_err   = res_err_q;
    assign bus.div_start = start_q;
    assign bus.div_dvd   = dvd_q;
    assign bus.div_dvs   = dvs_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Directed testbench for div_share_arb. The divider is played by hand-driven
// result pulses; inputs change and outputs are sampled on the falling edge.
module tb_div_share_arb;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   ndone;

    always #5 clk = ~clk;

    div_share_arb_if #(.W(10)) bus ();

    div_share_arb #(.W(10), .TMO(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One divider job from the IDLE cycle in which the request is visible.
    // evt = {dvz, ovf, valid} driven during the first WAIT cycle.
    task automatic job(input string nm, input logic tag, input logic [9:0] edvd,
                       input logic [9:0] edvs, input logic [2:0] evt,
                       input logic [9:0] q, input logic [9:0] eq, input logic [1:0] eerr);
        step();
        chk({nm, ".ack0"}, 32'(bus.ack0), 32'(!tag));
        chk({nm, ".ack1"}, 32'(bus.ack1), 32'(tag));
        chk({nm, ".start"}, 32'(bus.div_start), 32'd1);
        chk({nm, ".dvd"}, 32'(bus.div_dvd), 32'(edvd));
        chk({nm, ".dvs"}, 32'(bus.div_dvs), 32'(edvs));
        step();
        chk({nm, ".wait_start"}, 32'(bus.div_start), 32'd0);
        chk({nm, ".wait_ack"}, 32'({bus.ack0, bus.ack1}), 32'd0);
        chk({nm, ".wait_dvd"}, 32'(bus.div_dvd), 32'(edvd));
        bus.div_dvz   = evt[2];
        bus.div_ovf   = evt[1];
        bus.div_valid = evt[0];
        bus.div_q     = q;
        step();
        bus.div_dvz   = 1'b0;
        bus.div_ovf   = 1'b0;
        bus.div_valid = 1'b0;
        bus.div_q     = 10'd0;
        chk({nm, ".done0"}, 32'(bus.done0), 32'(!tag));
        chk({nm, ".done1"}, 32'(bus.done1), 32'(tag));
        chk({nm, ".res_q"}, 32'(bus.res_q), 32'(eq));
        chk({nm, ".res_err"}, 32'(bus.res_err), 32'(eerr));
        step();
        chk({nm, ".idle_hs"}, 32'({bus.ack0, bus.ack1, bus.done0, bus.done1}), 32'd0);
        chk({nm, ".idle_res"}, 32'({bus.res_q, bus.res_err}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.dvd0 = 10'd0; bus.dvs0 = 10'd0; bus.dvd1 = 10'd0; bus.dvs1 = 10'd0;
        bus.div_busy = 1'b0; bus.div_valid = 1'b0; bus.div_ovf = 1'b0;
        bus.div_dvz = 1'b0; bus.div_q = 10'd0;
        @(negedge clk);
        chk("rst.hs", 32'({bus.ack0, bus.ack1, bus.done0, bus.done1, bus.div_start}), 32'd0);
        chk("rst.res", 32'({bus.res_q, bus.res_err}), 32'd0);
        chk("rst.ops", 32'({bus.div_dvd, bus.div_dvs}), 32'd0);
        rst = 1'b1;
        step();

        // Single job: 100 / 7 = 14.
        bus.req0 = 1'b1; bus.dvd0 = 10'd100; bus.dvs0 = 10'd7;
        step();
        chk("single.ack0", 32'(bus.ack0), 32'd1);
        chk("single.ack1", 32'(bus.ack1), 32'd0);
        chk("single.start", 32'(bus.div_start), 32'd1);
        chk("single.dvd", 32'(bus.div_dvd), 32'd100);
        chk("single.dvs", 32'(bus.div_dvs), 32'd7);
        bus.req0 = 1'b0;
        step();
        chk("single.wait", 32'({bus.ack0, bus.div_start, bus.done0}), 32'd0);
        bus.div_valid = 1'b1; bus.div_q = 10'd14;
        step();
        bus.div_valid = 1'b0; bus.div_q = 10'd0;
        chk("single.done0", 32'(bus.done0), 32'd1);
        chk("single.done1", 32'(bus.done1), 32'd0);
        chk("single.res_q", 32'(bus.res_q), 32'd14);
        chk("single.res_err", 32'(bus.res_err), 32'd0);
        step();
        chk("single.after", 32'({bus.done0, bus.res_q}), 32'd0);

        // Tie after reset: 0, 1, then 0 again.
        do_reset();
        bus.req0 = 1'b1; bus.dvd0 = 10'd20; bus.dvs0 = 10'd4;
        bus.req1 = 1'b1; bus.dvd1 = 10'd30; bus.dvs1 = 10'd3;
        job("tie1", 1'b0, 10'd20, 10'd4, 3'b001, 10'd5, 10'd5, 2'b00);
        job("tie2", 1'b1, 10'd30, 10'd3, 3'b001, 10'd10, 10'd10, 2'b00);
        job("tie3", 1'b0, 10'd20, 10'd4, 3'b001, 10'd5, 10'd5, 2'b00);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();

        // Zero divisor from requester 1: no start, no ack, done next cycle.
        bus.req1 = 1'b1; bus.dvd1 = 10'd55; bus.dvs1 = 10'd0;
        step();
        bus.req1 = 1'b0;
        chk("dvz0.start", 32'(bus.div_start), 32'd0);
        chk("dvz0.ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("dvz0.done", 32'({bus.done0, bus.done1}), 32'b01);
        chk("dvz0.res_q", 32'(bus.res_q), 32'd0);
        chk("dvz0.res_err", 32'(bus.res_err), 32'b01);
        step();
        chk("dvz0.after", 32'({bus.done1, bus.div_start, bus.res_err}), 32'd0);

        // Overflow with requester 1 pending; 1 is served right after.
        bus.req0 = 1'b1; bus.dvd0 = 10'd500; bus.dvs0 = 10'd1;
        bus.req1 = 1'b1; bus.dvd1 = 10'd90;  bus.dvs1 = 10'd9;
        job("ovf", 1'b0, 10'd500, 10'd1, 3'b010, 10'd77, 10'd0, 2'b10);
        bus.req0 = 1'b0;
        job("pend", 1'b1, 10'd90, 10'd9, 3'b001, 10'd10, 10'd10, 2'b00);
        bus.req1 = 1'b0;

        // Event priority, lone requester granted back-to-back.
        bus.req0 = 1'b1; bus.dvd0 = 10'd7; bus.dvs0 = 10'd2;
        job("prio_dvz", 1'b0, 10'd7, 10'd2, 3'b111, 10'd3, 10'd0, 2'b01);
        job("prio_ovf", 1'b0, 10'd7, 10'd2, 3'b011, 10'd3, 10'd0, 2'b10);
        bus.req0 = 1'b0;
        step();

        // Reset in WAIT: outputs clear at once, no stale done afterwards.
        bus.req0 = 1'b1; bus.dvd0 = 10'd40; bus.dvs0 = 10'd8;
        step();
        bus.req0 = 1'b0;
        step();
        chk("rstmid.held", 32'(bus.div_dvd), 32'd40);
        #2 rst = 1'b0;
        #1;
        chk("rstmid.ops", 32'({bus.div_dvd, bus.div_dvs}), 32'd0);
        chk("rstmid.hs", 32'({bus.ack0, bus.ack1, bus.done0, bus.done1, bus.div_start}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.div_valid = 1'b1; bus.div_q = 10'd9;
        step();
        bus.div_valid = 1'b0; bus.div_q = 10'd0;
        step();
        chk("rstmid.nostale", 32'({bus.done0, bus.done1, bus.res_q}), 32'd0);
        bus.req0 = 1'b1;
        job("rstmid.new", 1'b0, 10'd40, 10'd8, 3'b001, 10'd5, 10'd5, 2'b00);
        bus.req0 = 1'b0;
        step();

        // Divider that never answers.
        bus.req0 = 1'b1; bus.dvd0 = 10'd9; bus.dvs0 = 10'd3;
        step();
        bus.req0 = 1'b0;
        chk("tmo.ack0", 32'(bus.ack0), 32'd1);
        ndone = 0;
`ifdef DIV_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done0 || bus.done1) ndone++;
        end
        chk("tmo.early_done", 32'(ndone), 32'd0);
        step();
        chk("tmo.done0", 32'(bus.done0), 32'd1);
        chk("tmo.res_err", 32'(bus.res_err), 32'b11);
        chk("tmo.res_q", 32'(bus.res_q), 32'd0);
        step();
`else
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.done0 || bus.done1) ndone++;
        end
        chk("tmo.no_done", 32'(ndone), 32'd0);
        do_reset();
`endif
        chk("end.idle", 32'({bus.done0, bus.done1, bus.res_err}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
